muldiv_unit: RTL

// Iterative RV32M multiply/divide unit; decodes func3 of M-extension R-type ops (func7=0000001) into its own

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_datapath.sv | 112 +++++++++++
 rtl/muldiv_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// M-extension op encodings (func3), the func7 value and the FSM states.
package muldiv_pkg;

  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // MUL treats both operands as signed; its low half is sign-agnostic anyway.
  function automatic logic signed_a(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic signed_b(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Datapath: operand sign conversion, one shared adder/subtractor, product /
// remainder shift registers and the final sign fix into the result register.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            finish,
  input  logic            fast,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] fast_value,
  output logic [XLEN-1:0] result
);

  op_e               op_reg;
  logic              neg_a_reg, neg_b_reg;
  logic [XLEN-1:0]   addend_reg, acc_reg, low_reg, result_reg;
  logic [XLEN-1:0]   acc_next, low_next, result_next;
  logic              sa, sb, is_div, carry;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     add_a, add_b;
  logic [XLEN+1:0]   sum;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  always_comb begin
    sa    = op_a[XLEN-1] & signed_a(op_e'(func3));
    sb    = op_b[XLEN-1] & signed_b(op_e'(func3));
    mag_a = sa ? -op_a : op_a;
    mag_b = sb ? -op_b : op_b;
  end

  // Multiply adds the held multiplicand into the high half; divide subtracts
  // the divisor from the shifted partial remainder (carry-out = no borrow).
  always_comb begin
    is_div = op_reg[2];
    if (is_div) begin
      add_a = {acc_reg, low_reg[XLEN-1]};
      add_b = ~{1'b0, addend_reg};
    end else begin
      add_a = {1'b0, acc_reg};
      add_b = low_reg[0] ? {1'b0, addend_reg} : '0;
    end
    sum   = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, is_div};
    carry = sum[XLEN+1];
    if (is_div) begin
      acc_next = carry ? sum[XLEN-1:0] : add_a[XLEN-1:0];
      low_next = {low_reg[XLEN-2:0], carry};
    end else begin
      acc_next = sum[XLEN:1];
      low_next = {sum[0], low_reg[XLEN-1:1]};
    end
  end

  // Sign fix works on the post-step values so it lands on the edge into DONE.
  always_comb begin
    prod     = {acc_next, low_next};
    prod_fix = (neg_a_reg ^ neg_b_reg) ? -prod : prod;
    quot_fix = (neg_a_reg ^ neg_b_reg) ? -low_next : low_next;
    rem_fix  = neg_a_reg ? -acc_next : acc_next;
    result_next = result_reg;
    if (fast) begin
      result_next = fast_value;
    end else if (finish) begin
      case (op_reg)
        OP_MUL:                       result_next = prod_fix[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: result_next = prod_fix[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              result_next = quot_fix;
        default:                      result_next = rem_fix;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= OP_MUL;
      neg_a_reg  <= 1'b0;
      neg_b_reg  <= 1'b0;
      addend_reg <= '0;
      acc_reg    <= '0;
      low_reg    <= '0;
      result_reg <= '0;
    end else begin
      if (load) begin
        op_reg    <= op_e'(func3);
        neg_a_reg <= sa;
        neg_b_reg <= sb;
        acc_reg   <= '0;
        if (func3[2]) begin
          addend_reg <= mag_b;
          low_reg    <= mag_a;
        end else begin
          addend_reg <= mag_a;
          low_reg    <= mag_b;
        end
      end else if (step) begin
        acc_reg <= acc_next;
        low_reg <= low_next;
      end
      result_reg <= result_next;
    end
  end

  assign result = result_reg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter, start/done
// handshake and the divide-by-zero / signed-overflow fast path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN + 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             accept, div_zero, overflow, fast_path, step, finish;
  logic [XLEN-1:0]  fast_value;

  assign busy   = (state_reg == ST_MUL) || (state_reg == ST_DIV);
  assign done   = (state_reg == ST_DONE);
  assign accept = start && !busy && !flush;
  assign step   = busy && !flush;
  assign finish = step && (cnt_reg == '0);

  // Divide corner cases resolve at accept and never enter the iteration.
  always_comb begin
    div_zero   = (op_b == '0);
    overflow   = !func3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    fast_path  = func3[2] && (div_zero || overflow);
    fast_value = '0;
    if (div_zero) begin
      fast_value = func3[1] ? op_a : '1;
    end else if (overflow) begin
      fast_value = func3[1] ? '0 : op_a;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_next = fast_path ? ST_DONE : (func3[2] ? ST_DIV : ST_MUL);
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_reg == '0) begin
            state_next = ST_DONE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept && !fast_path) begin
        cnt_reg <= CNT_W'(XLEN - 1);
      end else if (step && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && !fast_path),
    .step      (step),
    .finish    (finish),
    .fast      (accept && fast_path),
    .func3     (func3),
    .op_a      (op_a),
    .op_b      (op_b),
    .fast_value(fast_value),
    .result    (result)
  );

endmodule
